// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO with a launch controller that feeds a UART transmitter.
// Define UART_TX_FIFO_OVF_FLAG_EN to build the sticky write-when-full overflow flag.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done_tick,
    output logic              busy,
    input  logic              ovf_clr,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    state_t            state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign busy  = (state_q != IDLE) || !empty;
    assign count = count_q;

    // full is taken from the pre-edge count, so a pop in the same cycle cannot rescue a write
    assign push = wr_en && !full;
    assign pop  = (state_q == IDLE) && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // tx_done_tick only matters in WAIT; LOAD always advances after its single cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = LOAD;
            LOAD:    state_d = WAIT;
            WAIT:    if (tx_done_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tx_data holds its value between launches so the transmitter may sample it late
    always_comb begin
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if ((state_q == IDLE) && !empty) begin
            tx_start_d = 1'b1;
            tx_data_d  = mem[rd_ptr_q];
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_OVF_FLAG_EN
    logic overflow_q, overflow_d;

    // A set in the same cycle as a clear takes priority
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side byte buffer and launch controller that sits directly upstream of the UART transmitter. Accepts bytes from the host side with a single-cycle write strobe and stores them in a synchronous FIFO. Issues a one-cycle tx_start with the head byte on tx_data whenever the transmitter is free. Waits for the transmitter's tx_done_tick before launching the next byte.

Parameters:
DATA_W, 8, byte width; must match transmitter tx_data width
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (default 16 entries)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe; pushes wr_data when not full
wr_data  input  DATA_W  byte to enqueue
full  output  1  FIFO holds 2**ADDR_W entries
empty  output  1  FIFO holds 0 entries
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
tx_start  output  1  one-cycle launch pulse to transmitter
tx_data  output  DATA_W  byte presented with tx_start, held until next launch
tx_done_tick  input  1  transmitter completion pulse (end of stop bit)
busy  output  1  (ctrl state != IDLE) OR !empty
ovf_clr  input  1  clears overflow (used only with feature enabled)
overflow  output  1  sticky write-when-full flag (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous): rd/wr pointers 0, count 0, empty=1, full=0, state IDLE, tx_start=0, tx_data=0, overflow=0, busy=0. Memory contents not reset.
- Reset asserted mid-transmission discards all queued bytes; no tx_start until new writes arrive.
- Clocking: memory, pointers, count, state, tx_start and tx_data are all registered. full, empty and busy are decoded from registered count and state.
- Push: wr_en && !full → mem[wr_ptr] <= wr_data, wr_ptr++.
- Pointers wrap modulo 2**ADDR_W.
- Write while full is dropped, even if a pop occurs in the same cycle. full is evaluated on the pre-edge count.
- Pop occurs only in the controller IDLE→LOAD transition: rd_ptr++.
- Simultaneous push and pop: count unchanged.
- Controller FSM:
  - IDLE: if !empty → capture tx_data <= mem[rd_ptr], pop, tx_start <= 1, go LOAD. Else stay.
  - LOAD: tx_start is high for exactly this one cycle. tx_start <= 0, go WAIT.
  - WAIT: stay until tx_done_tick=1, then go IDLE.
- tx_done_tick in IDLE or LOAD is ignored; no state change and no pop.
- Latency: write at cycle W into an empty FIFO with controller IDLE → empty=0 at W+1, tx_start=1 at W+2.
- Back-to-back launch: tx_done_tick at cycle T with FIFO non-empty → IDLE at T+1, tx_start=1 at T+2.
- tx_data is stable from the tx_start cycle until the next LOAD. The transmitter latches it in the tx_start cycle.
- Count arithmetic is ADDR_W+1 bits. It never exceeds 2**ADDR_W and never underflows.

Optional Feature:
Macro UART_TX_FIFO_OVF_FLAG_EN.
- Defined: overflow is a register. It sets on the cycle after wr_en && full and stays set until ovf_clr=1. If set and clear occur in the same cycle, set wins. Reset value 0.
- Not defined: overflow is constant 0, ovf_clr is ignored, and no overflow register is built. Dropped-write behaviour is otherwise identical.

Test Plan:
1. Write 0xA5 once, tx_done_tick returned 20 cycles after tx_start → tx_start high exactly 1 cycle at W+2 with tx_data=0xA5; empty=1, busy=0 one cycle after done tick.
2. Write 0x00..0x0F on consecutive cycles while the transmitter model is stalled → after the first launch count peaks at 15, full never asserts. Bytes emerge in order 0x00..0x0F, each tx_start exactly 2 cycles after the previous tx_done_tick.
3. With the transmitter stalled (no tx_done_tick), write 17 bytes after the first launch has popped its byte → 16 stored, full=1, 17th dropped, count=16. With macro: overflow=1 until ovf_clr pulse, then 0. Without macro: overflow stays 0.
4. FIFO holding 3 bytes, controller IDLE: wr_en coincides with the IDLE→LOAD pop → count stays 3, and the new byte is transmitted 4th in order.
5. Spurious tx_done_tick while IDLE with an empty FIFO, and while in LOAD → no state change, no pop, no tx_start.
6. Assert reset_n low for 1 cycle while in WAIT with 5 bytes queued → count=0, empty=1, tx_start=0, tx_data=0, overflow=0 immediately. No further tx_start without new writes.
